// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register-port arbiter: FSM state encoding,
// grant index constants and the read-timeout counter width.
// ---------------------------------------------------------------------------
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam logic GRANT_M0 = 1'b0;
   localparam logic GRANT_M1 = 1'b1;

   // Wide enough for RD_TIMEOUT up to 255.
   localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin picker, purely combinational. The last_grant state
// is held by the parent so the pick only takes effect when the parent
// actually accepts a request.
//   req[1:0]    in   request vector, bit N = requester N
//   last_grant  in   index of the most recent grant
//   grant       out  index of the winner (only meaningful when req != 0)
// ---------------------------------------------------------------------------
module rr_arbiter2
   import reg_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

   always_comb begin
      grant = GRANT_M0;
      unique case (req)
         2'b01:   grant = GRANT_M0;
         2'b10:   grant = GRANT_M1;
         // Tie: hand the port to whoever did not have it last.
         2'b11:   grant = ~last_grant;
         default: grant = GRANT_M0;
      endcase
   end

endmodule

// File: rtl/reg_port_arbiter.sv
// ---------------------------------------------------------------------------
// reg_port_arbiter
// Shares the single reg_bank access port between M0 (AXI4-Lite side) and
// M1 (local hardware master). Accesses are serialised one at a time with
// round-robin fairness; reads are guarded by a timeout that completes the
// access with err=1 and rdata=0 if reg_rd_valid never arrives.
//   clk, rst_n                  clock, asynchronous active-low reset
//   mN_req/we/addr/wdata/wstrb  requester N access (held until mN_ack)
//   mN_ack/rdata/err            one-cycle completion with read data/error
//   reg_wr_*                    write port to reg_bank (valid with reg_wr_en)
//   reg_rd_en/addr              read request to reg_bank
//   reg_rd_data/valid           read response from reg_bank
//   busy                        high whenever the FSM is not IDLE
// Every output comes straight from a flop.
// ---------------------------------------------------------------------------
module reg_port_arbiter
   import reg_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int RD_TIMEOUT = 16
)(
   input  logic                    clk,
   input  logic                    rst_n,

   input  logic                    m0_req,
   input  logic                    m0_we,
   input  logic [ADDR_WIDTH-1:0]   m0_addr,
   input  logic [DATA_WIDTH-1:0]   m0_wdata,
   input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
   output logic                    m0_ack,
   output logic [DATA_WIDTH-1:0]   m0_rdata,
   output logic                    m0_err,

   input  logic                    m1_req,
   input  logic                    m1_we,
   input  logic [ADDR_WIDTH-1:0]   m1_addr,
   input  logic [DATA_WIDTH-1:0]   m1_wdata,
   input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
   output logic                    m1_ack,
   output logic [DATA_WIDTH-1:0]   m1_rdata,
   output logic                    m1_err,

   output logic                    reg_wr_en,
   output logic [ADDR_WIDTH-1:0]   reg_wr_addr,
   output logic [DATA_WIDTH-1:0]   reg_wr_data,
   output logic [DATA_WIDTH/8-1:0] reg_wr_strb,
   output logic                    reg_rd_en,
   output logic [ADDR_WIDTH-1:0]   reg_rd_addr,
   input  logic [DATA_WIDTH-1:0]   reg_rd_data,
   input  logic                    reg_rd_valid,

   output logic                    busy
);

   arb_state_t state, state_next;

   logic                    last_grant;
   logic                    grant_win;
   logic                    any_req;

   // Transaction fields captured in IDLE; later request changes are ignored.
   logic                    lat_grant;
   logic                    lat_we;
   logic [ADDR_WIDTH-1:0]   lat_addr;
   logic [DATA_WIDTH-1:0]   lat_wdata;
   logic [DATA_WIDTH/8-1:0] lat_wstrb;

   logic [CNT_WIDTH-1:0]    cnt;
   logic                    timeout_hit;

   logic                    done_now;
   logic [DATA_WIDTH-1:0]   done_rdata;
   logic                    done_err;

   assign any_req     = m0_req | m1_req;
   assign timeout_hit = (cnt == CNT_WIDTH'(RD_TIMEOUT - 1));

   rr_arbiter2 u_rr (
      .req        ({m1_req, m0_req}),
      .last_grant (last_grant),
      .grant      (grant_win)
   );

   // Next state plus the completion event that fires on entry to DONE.
   always_comb begin
      state_next = state;
      done_now   = 1'b0;
      done_rdata = '0;
      done_err   = 1'b0;
      unique case (state)
         IDLE: begin
            if (any_req) state_next = ISSUE;
         end
         ISSUE: begin
            if (lat_we) begin
               state_next = DONE;
               done_now   = 1'b1;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            // Valid data wins over a timeout landing in the same cycle.
            if (reg_rd_valid) begin
               state_next = DONE;
               done_now   = 1'b1;
               done_rdata = reg_rd_data;
            end else if (timeout_hit) begin
               state_next = DONE;
               done_now   = 1'b1;
               done_err   = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= GRANT_M1;
         lat_grant  <= GRANT_M0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_wstrb  <= '0;
         cnt        <= '0;
         reg_wr_en  <= 1'b0;
         reg_rd_en  <= 1'b0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
         m0_err     <= 1'b0;
         m1_err     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // Strobes are single-cycle pulses unless re-asserted below.
         reg_wr_en <= 1'b0;
         reg_rd_en <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         busy      <= (state_next != IDLE);

         if (state == IDLE && any_req) begin
            last_grant <= grant_win;
            lat_grant  <= grant_win;
            if (grant_win == GRANT_M1) begin
               lat_we    <= m1_we;
               lat_addr  <= m1_addr;
               lat_wdata <= m1_wdata;
               lat_wstrb <= m1_wstrb;
               reg_wr_en <= m1_we;
               reg_rd_en <= ~m1_we;
            end else begin
               lat_we    <= m0_we;
               lat_addr  <= m0_addr;
               lat_wdata <= m0_wdata;
               lat_wstrb <= m0_wstrb;
               reg_wr_en <= m0_we;
               reg_rd_en <= ~m0_we;
            end
         end

         if (state == ISSUE)
            cnt <= '0;
         else if (state == WAIT && !done_now)
            cnt <= cnt + 1'b1;

         // Ack is raised for the DONE cycle; rdata/err hold until the next
         // ack on the same port.
         if (done_now) begin
            if (lat_grant == GRANT_M1) begin
               m1_ack   <= 1'b1;
               m1_rdata <= done_rdata;
               m1_err   <= done_err;
            end else begin
               m0_ack   <= 1'b1;
               m0_rdata <= done_rdata;
               m0_err   <= done_err;
            end
         end
      end
   end

   // Latched fields feed the reg_bank port directly; they only matter while
   // the matching enable is high.
   assign reg_wr_addr = lat_addr;
   assign reg_wr_data = lat_wdata;
   assign reg_wr_strb = lat_wstrb;
   assign reg_rd_addr = lat_addr;

endmodule
